// File: rtl/cr_tcipif_bus_arb.sv
// Round-robin arbiter and single-outstanding sequencer for the ibus/dbus masters onto tcipif.
// Optional BUSY timeout is enabled by defining CR_TCIPIF_ARB_TIMEOUT_EN.
module cr_tcipif_bus_arb #(
    parameter int unsigned     TO_W   = 8,
    parameter logic [TO_W-1:0] TO_CYC = 8'd255
) (
    input  logic        sel_cpuclk,
    input  logic        cpurst_b,

    input  logic        ibus_req_i,
    input  logic        ibus_write_i,
    input  logic        ibus_acc_deny_i,
    input  logic [31:0] ibus_addr_i,

    input  logic        dbus_req_i,
    input  logic        dbus_write_i,
    input  logic        dbus_acc_deny_i,
    input  logic [31:0] dbus_addr_i,
    input  logic [31:0] dbus_wdata_i,

    output logic        ibus_grnt_o,
    output logic        ibus_trans_cmplt_o,
    output logic        ibus_data_vld_o,
    output logic        ibus_acc_err_o,
    output logic [31:0] ibus_rdata_o,

    output logic        dbus_grnt_o,
    output logic        dbus_trans_cmplt_o,
    output logic        dbus_data_vld_o,
    output logic        dbus_acc_err_o,
    output logic [31:0] dbus_rdata_o,

    output logic        tcipif_req_o,
    output logic        tcipif_write_o,
    output logic        tcipif_src_o,
    output logic [31:0] tcipif_addr_o,
    output logic [31:0] tcipif_wdata_o,

    input  logic        tcipif_grnt_i,
    input  logic        tcipif_trans_cmplt_i,
    input  logic        tcipif_data_vld_i,
    input  logic        tcipif_acc_err_i,
    input  logic [31:0] tcipif_rdata_i
);

    typedef enum logic [2:0] {StIdle, StBusyI, StBusyD, StErrI, StErrD} state_e;

    state_e      state_q;
    logic        last_owner_q;

    logic        any_req;
    logic        arb_dbus;
    logic        win_deny;
    logic        idle;
    logic        grant;
    logic        busy;
    logic        to_fire;

    logic        rsp_dbus;
    logic        rsp_cmplt;
    logic        rsp_vld;
    logic        rsp_err;
    logic [31:0] rsp_rdata;

    assign any_req  = ibus_req_i | dbus_req_i;
    // On a tie the master that did not own the port last wins.
    assign arb_dbus = dbus_req_i & (~ibus_req_i | ~last_owner_q);
    assign win_deny = arb_dbus ? dbus_acc_deny_i : ibus_acc_deny_i;
    assign idle     = (state_q == StIdle);
    assign grant    = idle & any_req & (win_deny | tcipif_grnt_i);
    assign busy     = (state_q == StBusyI) | (state_q == StBusyD);

`ifdef CR_TCIPIF_ARB_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt_q;

    // A slave completion in the same cycle as the timeout takes priority.
    assign to_fire = busy & ~tcipif_trans_cmplt_i & (to_cnt_q == TO_CYC);

    always_ff @(posedge sel_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            to_cnt_q <= '0;
        end else if (grant) begin
            to_cnt_q <= '0;
        end else if (busy & ~tcipif_trans_cmplt_i) begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end
`else
    logic unused_to_cyc;

    assign to_fire       = 1'b0;
    assign unused_to_cyc = ^TO_CYC;
`endif

    always_ff @(posedge sel_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q      <= StIdle;
            last_owner_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (grant) begin
                        last_owner_q <= arb_dbus;
                        if (win_deny) begin
                            state_q <= arb_dbus ? StErrD : StErrI;
                        end else begin
                            state_q <= arb_dbus ? StBusyD : StBusyI;
                        end
                    end
                end
                StBusyI, StBusyD: begin
                    if (tcipif_trans_cmplt_i | to_fire) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        rsp_dbus  = (state_q == StBusyD) | (state_q == StErrD);
        rsp_cmplt = 1'b0;
        rsp_vld   = 1'b0;
        rsp_err   = 1'b0;
        rsp_rdata = '0;
        if ((state_q == StErrI) || (state_q == StErrD) || to_fire) begin
            rsp_cmplt = 1'b1;
            rsp_err   = 1'b1;
        end else if (busy) begin
            rsp_cmplt = tcipif_trans_cmplt_i;
            rsp_vld   = tcipif_data_vld_i;
            rsp_err   = tcipif_acc_err_i;
            rsp_rdata = tcipif_data_vld_i ? tcipif_rdata_i : '0;
        end
    end

    assign tcipif_req_o   = idle & any_req & ~win_deny;
    assign tcipif_src_o   = arb_dbus;
    assign tcipif_write_o = arb_dbus ? dbus_write_i : ibus_write_i;
    assign tcipif_addr_o  = arb_dbus ? dbus_addr_i : ibus_addr_i;
    assign tcipif_wdata_o = arb_dbus ? dbus_wdata_i : '0;

    assign ibus_grnt_o        = grant & ~arb_dbus;
    assign dbus_grnt_o        = grant & arb_dbus;

    assign ibus_trans_cmplt_o = rsp_cmplt & ~rsp_dbus;
    assign ibus_data_vld_o    = rsp_vld & ~rsp_dbus;
    assign ibus_acc_err_o     = rsp_err & ~rsp_dbus;
    assign ibus_rdata_o       = rsp_dbus ? '0 : rsp_rdata;

    assign dbus_trans_cmplt_o = rsp_cmplt & rsp_dbus;
    assign dbus_data_vld_o    = rsp_vld & rsp_dbus;
    assign dbus_acc_err_o     = rsp_err & rsp_dbus;
    assign dbus_rdata_o       = rsp_dbus ? rsp_rdata : '0;

endmodule
